// File: rtl/saturn_bus_pkg.sv
// Shared command codes, FSM state type and sizing constants for the saturn bus arbiter.
package saturn_bus_pkg;

  localparam int ADDR_W       = 20;
  localparam int CNT_W        = 3;
  localparam int ADDR_NIBBLES = 5;

  localparam logic [3:0] CMD_NOP         = 4'h0;
  localparam logic [3:0] CMD_PC_READ     = 4'h2;
  localparam logic [3:0] CMD_DP_READ     = 4'h3;
  localparam logic [3:0] CMD_DP_WRITE    = 4'h4;
  localparam logic [3:0] CMD_LOAD_PC     = 4'h5;
  localparam logic [3:0] CMD_LOAD_DP     = 4'h6;
  localparam logic [3:0] CMD_CONFIGURE   = 4'h7;
  localparam logic [3:0] CMD_UNCONFIGURE = 4'h8;
  localparam logic [3:0] CMD_BUS_RESET   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } bus_state_t;

endpackage

// File: rtl/saturn_bus_addr_match.sv
// One slot's mask/base/configured registers and its address comparators.
// The first CONFIGURE write stores the mask, the second stores the base and configures the slot.
module saturn_bus_addr_match #(
  parameter int ADDR_W    = 20,
  parameter bit ALWAYS_ON = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cfg_wr,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_cfg_addr,
  input  logic [ADDR_W-1:0] i_ptr,
  output logic              o_mask_loaded,
  output logic              o_configured,
  output logic              o_ptr_hit,
  output logic              o_addr_hit
);

  logic [ADDR_W-1:0] mask_reg;
  logic [ADDR_W-1:0] base_reg;
  logic              mask_loaded_reg;
  logic              configured_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mask_reg        <= '0;
      base_reg        <= '0;
      mask_loaded_reg <= 1'b0;
      configured_reg  <= 1'b0;
    end else if (i_clear) begin
      mask_loaded_reg <= 1'b0;
      configured_reg  <= 1'b0;
    end else if (i_cfg_wr) begin
      if (!mask_loaded_reg) begin
        mask_reg        <= i_cfg_addr;
        mask_loaded_reg <= 1'b1;
      end else begin
        base_reg        <= i_cfg_addr;
        mask_loaded_reg <= 1'b0;
        configured_reg  <= 1'b1;
      end
    end
  end

  // The ROM slot never receives writes, so its zero mask makes it match everything.
  assign o_configured  = ALWAYS_ON | configured_reg;
  assign o_mask_loaded = mask_loaded_reg;
  assign o_ptr_hit     = o_configured && ((i_ptr & mask_reg) == (base_reg & mask_reg));
  assign o_addr_hit    = configured_reg && ((i_cfg_addr & mask_reg) == (base_reg & mask_reg));

endmodule

// File: rtl/saturn_bus_arbiter.sv
// Bus arbiter/configuration sequencer: tracks PC/DP, runs CONFIGURE/UNCONFIGURE, selects the data slot.
// Define SATURN_BUS_UNCONFIGURE_EN to let UNCONFIGURE release slots; otherwise it only consumes its address.
module saturn_bus_arbiter #(
  parameter int N_SLOTS = 4,
  parameter int ADDR_W  = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_bus_clk_en,
  input  logic                 i_bus_is_data,
  input  logic [3:0]           i_ctrl_nibble,
  input  logic [4*N_SLOTS-1:0] i_slot_nibble,
  output logic [3:0]           o_ctrl_nibble,
  output logic [N_SLOTS-1:0]   o_slot_sel,
  output logic [ADDR_W-1:0]    o_pc,
  output logic [ADDR_W-1:0]    o_dp,
  output logic [3:0]           o_cmd,
  output logic [2:0]           o_cfg_slot,
  output logic                 o_bus_error
);
  import saturn_bus_pkg::*;

`ifdef SATURN_BUS_UNCONFIGURE_EN
  localparam bit UNCFG_EN = 1'b1;
`else
  localparam bit UNCFG_EN = 1'b0;
`endif
  localparam logic [N_SLOTS-1:0] HIGH_SLOTS = ~N_SLOTS'(1);

  bus_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] shift_reg, pc_reg, dp_reg;
  logic [3:0]        cmd_reg;
  logic [2:0]        cfg_slot_reg;
  logic              bus_error_reg;

  logic              cmd_beat, addr_beat, addr_done, data_beat, bus_reset_beat;
  logic              cfg_commit, cfg_second, uncfg_commit, uncfg_found;
  logic [ADDR_W-1:0] load_addr, ptr;
  logic [2:0]        lowest_free, win;
  logic [N_SLOTS-1:0] cfg_wr, clr, uncfg_clr, mask_loaded, configured, ptr_hit, addr_hit;

  assign cmd_beat       = i_bus_clk_en && !i_bus_is_data;
  assign addr_beat      = i_bus_clk_en && i_bus_is_data && (state_reg == ADDR);
  assign data_beat      = i_bus_clk_en && i_bus_is_data && (state_reg == DATA);
  assign addr_done      = addr_beat && (cnt_reg == CNT_W'(ADDR_NIBBLES - 1));
  assign bus_reset_beat = cmd_beat && (i_ctrl_nibble == CMD_BUS_RESET);
  // Low nibble arrives first, so each nibble enters at the top and the address settles after five.
  assign load_addr      = {i_ctrl_nibble, shift_reg[ADDR_W-1:4]};
  assign ptr            = (cmd_reg == CMD_PC_READ) ? pc_reg : dp_reg;
  assign cfg_commit     = addr_done && (cmd_reg == CMD_CONFIGURE) && (int'(cfg_slot_reg) < N_SLOTS);
  assign uncfg_commit   = UNCFG_EN && addr_done && (cmd_reg == CMD_UNCONFIGURE);
  assign cfg_second     = |(cfg_wr & mask_loaded);
  assign clr            = (bus_reset_beat ? HIGH_SLOTS : '0) | (uncfg_commit ? uncfg_clr : '0);

  always_comb begin
    cfg_wr = '0;
    for (int k = 1; k < N_SLOTS; k++)
      if (cfg_commit && (cfg_slot_reg == 3'(k))) cfg_wr[k] = 1'b1;
  end

  // UNCONFIGURE releases the highest matching slot; the next slot to configure is the lowest free one.
  always_comb begin
    uncfg_clr   = '0;
    uncfg_found = 1'b0;
    for (int k = N_SLOTS - 1; k >= 1; k--)
      if (!uncfg_found && addr_hit[k]) begin
        uncfg_clr[k] = 1'b1;
        uncfg_found  = 1'b1;
      end
    lowest_free = 3'(N_SLOTS);
    for (int k = N_SLOTS - 1; k >= 1; k--)
      if (!configured[k] || uncfg_clr[k]) lowest_free = 3'(k);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      saturn_bus_addr_match #(
        .ADDR_W    (ADDR_W),
        .ALWAYS_ON (gi == 0)
      ) u_match (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cfg_wr      (cfg_wr[gi]),
        .i_clear       (clr[gi]),
        .i_cfg_addr    (load_addr),
        .i_ptr         (ptr),
        .o_mask_loaded (mask_loaded[gi]),
        .o_configured  (configured[gi]),
        .o_ptr_hit     (ptr_hit[gi]),
        .o_addr_hit    (addr_hit[gi])
      );
    end
  endgenerate

  // Highest matching slot owns the nibble; slot 0 always matches so exactly one bit is set.
  always_comb begin
    win = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (ptr_hit[k]) win = 3'(k);
    o_slot_sel    = '0;
    o_ctrl_nibble = '0;
    for (int k = 0; k < N_SLOTS; k++)
      if (win == 3'(k)) begin
        o_slot_sel[k] = 1'b1;
        o_ctrl_nibble = i_slot_nibble[4*k +: 4];
      end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      pc_reg        <= '0;
      dp_reg        <= '0;
      cmd_reg       <= CMD_NOP;
      cfg_slot_reg  <= 3'd1;
      bus_error_reg <= 1'b0;
    end else begin
      bus_error_reg <= 1'b0;
      if (cmd_beat) begin
        cmd_reg       <= i_ctrl_nibble;
        cnt_reg       <= '0;
        shift_reg     <= '0;
        bus_error_reg <= (state_reg == ADDR);
        case (i_ctrl_nibble)
          CMD_LOAD_PC, CMD_LOAD_DP, CMD_CONFIGURE, CMD_UNCONFIGURE: state_reg <= ADDR;
          CMD_PC_READ, CMD_DP_READ, CMD_DP_WRITE:                   state_reg <= DATA;
          default:                                                  state_reg <= IDLE;
        endcase
        if (bus_reset_beat) cfg_slot_reg <= 3'd1;
      end else if (addr_beat) begin
        shift_reg <= load_addr;
        cnt_reg   <= cnt_reg + CNT_W'(1);
        if (addr_done) begin
          state_reg <= IDLE;
          if (cmd_reg == CMD_LOAD_PC) pc_reg <= load_addr;
          if (cmd_reg == CMD_LOAD_DP) dp_reg <= load_addr;
          if (cfg_second) cfg_slot_reg <= cfg_slot_reg + 3'd1;
          if (uncfg_commit) cfg_slot_reg <= lowest_free;
        end
      end else if (data_beat) begin
        if (cmd_reg == CMD_PC_READ) pc_reg <= pc_reg + ADDR_W'(1);
        else                        dp_reg <= dp_reg + ADDR_W'(1);
      end
    end
  end

  assign o_pc        = pc_reg;
  assign o_dp        = dp_reg;
  assign o_cmd       = cmd_reg;
  assign o_cfg_slot  = cfg_slot_reg;
  assign o_bus_error = bus_error_reg;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Scoreboard bench for saturn_bus_arbiter: a transaction-level model predicts every cycle's outputs,
// a separate monitor pops and compares them after each clock edge.
module tb_saturn_bus_arbiter;
  import saturn_bus_pkg::*;

  localparam int NS = 4;
  localparam int AW = 20;
  localparam int AMASK = 'hFFFFF;

  logic          clk = 1'b0;
  logic          rst, en, is_data;
  logic [3:0]    cn;
  logic [4*NS-1:0] snib;
  logic [3:0]    o_nib;
  logic [NS-1:0] o_sel;
  logic [AW-1:0] o_pc, o_dp;
  logic [3:0]    o_cmd;
  logic [2:0]    o_cfg;
  logic          o_err;

  always #5 clk = ~clk;

  saturn_bus_arbiter #(.N_SLOTS(NS), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_reset(rst), .i_bus_clk_en(en), .i_bus_is_data(is_data),
    .i_ctrl_nibble(cn), .i_slot_nibble(snib), .o_ctrl_nibble(o_nib), .o_slot_sel(o_sel),
    .o_pc(o_pc), .o_dp(o_dp), .o_cmd(o_cmd), .o_cfg_slot(o_cfg), .o_bus_error(o_err)
  );

  typedef struct {
    int id; int pc; int dp; int cmd; int cfg; int sel; int nib; int err;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int txn = 0;
  bit gaps = 0;

  // Reference model state: mode 0 idle, 1 collecting address, 2 data transfer.
  int m_pc, m_dp, m_cmd, m_cfg, m_mode, m_err;
  int m_mask[NS], m_base[NS];
  bit m_conf[NS], m_half[NS];
  int m_nibs[$];

  function automatic void model_reset();
    m_pc = 0; m_dp = 0; m_cmd = 0; m_cfg = 1; m_mode = 0; m_err = 0;
    m_nibs.delete();
    for (int k = 0; k < NS; k++) begin
      m_mask[k] = 0; m_base[k] = 0; m_conf[k] = (k == 0); m_half[k] = 0;
    end
  endfunction

  function automatic void model_apply(int a);
    case (m_cmd)
      5: m_pc = a;
      6: m_dp = a;
      7: if (m_cfg < NS) begin
           if (!m_half[m_cfg]) begin m_mask[m_cfg] = a; m_half[m_cfg] = 1; end
           else begin m_base[m_cfg] = a; m_half[m_cfg] = 0; m_conf[m_cfg] = 1; m_cfg++; end
         end
      8: begin
`ifdef SATURN_BUS_UNCONFIGURE_EN
           for (int k = NS - 1; k >= 1; k--)
             if (m_conf[k] && ((a & m_mask[k]) == (m_base[k] & m_mask[k]))) begin
               m_conf[k] = 0; m_half[k] = 0; break;
             end
           m_cfg = NS;
           for (int k = NS - 1; k >= 1; k--) if (!m_conf[k]) m_cfg = k;
`endif
         end
      default: ;
    endcase
  endfunction

  function automatic void model_step(bit r, bit e, bit d, int n);
    m_err = 0;
    if (r) model_reset();
    else if (e) begin
      if (!d) begin
        m_err = (m_mode == 1);
        m_cmd = n;
        m_nibs.delete();
        if (n >= 5 && n <= 8) m_mode = 1;
        else if (n >= 2 && n <= 4) m_mode = 2;
        else m_mode = 0;
        if (n == 15) begin
          for (int k = 1; k < NS; k++) begin m_conf[k] = 0; m_half[k] = 0; end
          m_cfg = 1;
        end
      end else if (m_mode == 1) begin
        m_nibs.push_back(n);
        if (m_nibs.size() == 5) begin
          int a;
          a = 0;
          for (int i = 0; i < 5; i++) a = a + (m_nibs[i] << (4 * i));
          model_apply(a);
          m_mode = 0;
          m_nibs.delete();
        end
      end else if (m_mode == 2) begin
        if (m_cmd == 2) m_pc = (m_pc + 1) & AMASK;
        else            m_dp = (m_dp + 1) & AMASK;
      end
    end
  endfunction

  function automatic int model_winner();
    int p, w;
    p = (m_cmd == 2) ? m_pc : m_dp;
    w = 0;
    for (int k = 0; k < NS; k++)
      if (m_conf[k] && ((p & m_mask[k]) == (m_base[k] & m_mask[k]))) w = k;
    return w;
  endfunction

  task automatic cycle(input bit r, input bit e, input bit d, input logic [3:0] n);
    exp_t x;
    int w;
    @(negedge clk);
    rst = r; en = e; is_data = d; cn = n;
    snib = (4*NS)'($urandom);
    model_step(r, e, d, int'(n));
    w = model_winner();
    x.id = txn; x.pc = m_pc; x.dp = m_dp; x.cmd = m_cmd; x.cfg = m_cfg;
    x.sel = 1 << w; x.nib = int'((snib >> (4 * w)) & 'hF); x.err = m_err;
    exp_q.push_back(x);
    txn++;
  endtask

  task automatic beat(input bit d, input logic [3:0] n);
    if (gaps) begin
      int g;
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      for (int i = 0; i < g; i++) cycle(0, 0, 1'($urandom), 4'($urandom));
    end
    cycle(0, 1, d, n);
  endtask

  task automatic load(input logic [3:0] c, input logic [19:0] a);
    beat(0, c);
    for (int i = 0; i < 5; i++) beat(1, a[4*i +: 4]);
  endtask

  task automatic data(input int n);
    for (int i = 0; i < n; i++) beat(1, 4'($urandom));
  endtask

  task automatic chk(input string name, input int id, input int act, input int want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL #%0d %s: got %0h, expected %0h", id, name, act, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a settled state; compare it against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", e.id, int'(o_pc), e.pc);
        chk("dp", e.id, int'(o_dp), e.dp);
        chk("cmd", e.id, int'(o_cmd), e.cmd);
        chk("cfg_slot", e.id, int'(o_cfg), e.cfg);
        chk("slot_sel", e.id, int'(o_sel), e.sel);
        chk("ctrl_nibble", e.id, int'(o_nib), e.nib);
        chk("bus_error", e.id, int'(o_err), e.err);
        $display("[TB] #%0d rst=%b en=%b d=%b n=%h pc=%05h dp=%05h cmd=%h cfg=%0d sel=%b nib=%h err=%b",
                 e.id, rst, en, is_data, cn, o_pc, o_dp, o_cmd, o_cfg, o_sel, o_nib, o_err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] addr_pool [6];
    int c;
    addr_pool[0] = 20'h80000; addr_pool[1] = 20'hFF000; addr_pool[2] = 20'hF0000;
    addr_pool[3] = 20'hC0000; addr_pool[4] = 20'h80010; addr_pool[5] = 20'hFFFFF;
    rst = 1; en = 0; is_data = 0; cn = 0; snib = '0;
    model_reset();

    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 4'h7);
    // Default mapping after reset, then PC load with wrap.
    beat(0, CMD_PC_READ); data(3);
    load(CMD_LOAD_PC, 20'hFFFFF); beat(0, CMD_PC_READ); data(2);
    // Slot 1 at 80000/FF000, select inside and just outside its window.
    load(CMD_CONFIGURE, 20'hFF000); load(CMD_CONFIGURE, 20'h80000);
    load(CMD_LOAD_DP, 20'h80010); beat(0, CMD_DP_READ); data(2);
    load(CMD_LOAD_DP, 20'h81000); beat(0, CMD_DP_READ); data(1);
    // Overlapping slot 2, then release of the higher slot.
    load(CMD_CONFIGURE, 20'hF0000); load(CMD_CONFIGURE, 20'h80000);
    load(CMD_LOAD_DP, 20'h80000); beat(0, CMD_DP_READ); data(1);
    load(CMD_UNCONFIGURE, 20'h80000);
    load(CMD_LOAD_DP, 20'h80000); beat(0, CMD_DP_WRITE); data(1);
    // Interrupted address load.
    beat(0, CMD_LOAD_DP); beat(1, 4'h3); beat(1, 4'h4); beat(0, CMD_PC_READ); data(2);
    // Reset in the middle of the base CONFIGURE.
    cycle(1, 0, 0, 0);
    load(CMD_CONFIGURE, 20'hFF000); beat(0, CMD_CONFIGURE); data(3);
    cycle(1, 1, 1, 4'h8);
    beat(1, 4'h8); beat(1, 4'h0);
    // Same configuration interrupted by BUS_RESET instead, with pointers preserved.
    load(CMD_CONFIGURE, 20'hFF000); load(CMD_CONFIGURE, 20'h80000);
    load(CMD_LOAD_DP, 20'h80010); beat(0, CMD_DP_READ); data(1);
    beat(0, CMD_BUS_RESET); data(2);
    beat(0, CMD_DP_READ); data(1);

    // Randomized traffic with clock-enable gaps and occasional resets.
    gaps = 1;
    for (int t = 0; t < 80; t++) begin
      logic [19:0] a;
      a = ($urandom_range(0, 1) == 0) ? addr_pool[$urandom_range(0, 5)] : 20'($urandom);
      c = $urandom_range(0, 15);
      if ($urandom_range(0, 39) == 0) cycle(1, 1'($urandom), 1'($urandom), 4'($urandom));
      if (c >= 5 && c <= 8) begin
        if ($urandom_range(0, 5) == 0) begin
          beat(0, 4'(c));
          for (int i = 0; i < $urandom_range(0, 4); i++) beat(1, a[4*i +: 4]);
        end else load(4'(c), a);
      end else if (c == 9 || c == 10) begin
        load(CMD_CONFIGURE, a);
      end else begin
        beat(0, 4'(c));
        data($urandom_range(0, 4));
      end
    end

    repeat (2) @(posedge clk);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
